hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32 core.
- It is the consumer end of the ID/EX stage register. It reads the EX-stage fields latched there (rd, decoded mem_read/reg_write, branch outcome, mul/div start) plus the ID-stage source registers.
- It drives the en/flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- It holds a multi-cycle mul/div occupancy FSM and 32-bit stall/flush performance counters.

Parameters:
- MD_LAT, 4: total cycles a mul/div instruction occupies EX; legal range 1..16. A value of 1 means no stall.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rs1_d  input  5  rs1 of the instruction in ID
- rs2_d  input  5  rs2 of the instruction in ID
- rs1_used  input  1  ID instruction reads rs1
- rs2_used  input  1  ID instruction reads rs2
- rd_e  input  5  rd of the instruction in EX (ID_EX output)
- mem_read_e  input  1  EX instruction is a load
- branch_taken_e  input  1  EX resolved a taken branch or jump (PC redirect)
- md_start_e  input  1  EX instruction is mul/div; held high while it remains in EX
- mem_wait  input  1  data memory not ready; the whole pipeline must freeze
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage register enables
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load a bubble (synchronous clear) into that register
- md_busy  output  1  FSM is in BUSY
- stall_cnt  output  CNT_W  count of cycles with pc_en=0 (out of reset)
- flush_cnt  output  CNT_W  count of cycles with a branch flush applied

Behaviour:
- Registered state: FSM {IDLE, BUSY}, md_cnt[3:0], stall_cnt, flush_cnt. All control outputs are combinational from state and inputs.
- Reset (rst=0): state=IDLE, md_cnt=0, both counters=0. All en outputs=0, all flush outputs=0, md_busy=0.
- load_use = mem_read_e & (rd_e!=0) & ((rs1_used & rs1_d==rd_e) | (rs2_used & rs2_d==rd_e)).
- md_stall, MD_LAT>1:
  - IDLE & md_start_e: md_stall=1; next state BUSY, md_cnt<=MD_LAT-2.
  - BUSY & md_cnt!=0: md_stall=1; md_cnt decrements.
  - BUSY & md_cnt==0: md_stall=0, so the instruction advances; next state IDLE.
  - Net effect: EX is occupied for exactly MD_LAT cycles, with MD_LAT-1 stall cycles.
- md_stall, MD_LAT==1: md_start_e is ignored and the FSM stays in IDLE.
- Priority, highest first:
  1. mem_wait=1: every en=0 and every flush=0. FSM state, md_cnt and flush_cnt hold; stall_cnt increments.
  2. md_stall: pc/if_id/id_ex en=0; ex_mem_flush=1 (bubble into MEM); mem_wb_en=1.
  3. branch_taken_e: all en=1; if_id_flush=1 and id_ex_flush=1 (squash the two younger instructions). Any simultaneous load_use is ignored.
  4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1; others en=1. Exactly one bubble per load-use pair.
  5. Otherwise: all en=1, all flush=0.
- A flush overrides its register's en: when flush=1 the register loads the bubble regardless of en.
- stall_cnt increments in every out-of-reset cycle where pc_en=0. flush_cnt increments in every cycle where case 3 applies. Both wrap modulo 2^CNT_W.
- A branch raised during mem_wait is not applied until mem_wait drops. It stays held in EX and is applied exactly once.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately (asynchronous); there is no residual stall after release.
- rd_e==0 never causes a load-use stall.

Test Plan:
- Load x5 in EX, `add x6,x5,x1` in ID (rs1_used=1) -> exactly 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1.
- branch_taken_e=1 while load_use is also true -> if_id_flush=id_ex_flush=1, pc_en=1, no stall; flush_cnt +1.
- MD_LAT=4, md_start_e held 4 cycles -> pc_en=0 for cycles 1-3 with ex_mem_flush=1 each; cycle 4 all en=1; md_busy high in cycles 2-4; stall_cnt=3.
- mem_wait=1 for 2 cycles in the middle of BUSY with md_cnt=1 -> all en=0, md_cnt held at 1. After release: 1 more stall cycle, then advance. Total stall_cnt=5 for MD_LAT=4.
- branch_taken_e=1 coincident with a 3-cycle mem_wait -> no flush while mem_wait=1; single flush in the first cycle after release; flush_cnt +1.
- Drive rst=0 asynchronously during BUSY -> outputs drop to 0 immediately; after release with md_start_e=0, FSM is IDLE, all en=1, counters=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: load-use interlock,
// branch squash, memory freeze and multi-cycle mul/div occupancy, plus perf counters.
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       rd_e,
    input  logic             mem_read_e,
    input  logic             branch_taken_e,
    input  logic             md_start_e,
    input  logic             mem_wait,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    // The first occupancy cycle is spent in IDLE, so BUSY counts down from MD_LAT-2.
    localparam logic [3:0] MD_INIT = (MD_LAT > 1) ? 4'(MD_LAT - 2) : 4'd0;

    md_state_t        state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic md_stall;
    logic branch_apply;

    always_comb begin
        load_use = mem_read_e && (rd_e != 5'd0) &&
                   ((rs1_used && (rs1_d == rd_e)) || (rs2_used && (rs2_d == rd_e)));
        md_stall = 1'b0;
        if (MD_LAT > 1) begin
            md_stall = ((state_q == IDLE) && md_start_e) ||
                       ((state_q == BUSY) && (md_cnt_q != 4'd0));
        end
        branch_apply = rst && !mem_wait && !md_stall && branch_taken_e;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!rst || mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (md_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (branch_taken_e) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // The FSM freezes along with the rest of the pipeline while memory is not ready.
    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_apply) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (!mem_wait && (MD_LAT > 1)) begin
            case (state_q)
                IDLE: begin
                    if (md_start_e) begin
                        state_d  = BUSY;
                        md_cnt_d = MD_INIT;
                    end
                end
                BUSY: begin
                    if (md_cnt_q != 4'd0) begin
                        md_cnt_d = md_cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign md_busy   = (state_q == BUSY);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LAT=4.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_e;
    logic        rs1_used, rs2_used, mem_read_e, branch_taken_e, md_start_e, mem_wait;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
    logic [31:0] stall_cnt, flush_cnt;

    int compared   = 0;
    int mismatched = 0;
    int exp_stall  = 0;
    int exp_flush  = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flushes}
    localparam logic [7:0] C_ZERO = 8'b00000_000;
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    // {pc, if_id, id_ex, mem_wb enables, ex_mem flush} during a mul/div stall
    localparam logic [4:0] C_MD   = 5'b00011;

    logic [7:0] ctrl;
    logic [4:0] ctrl_md;
    assign ctrl    = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush, ex_mem_flush};
    assign ctrl_md = {pc_en, if_id_en, id_ex_en, mem_wb_en, ex_mem_flush};

    hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_e(rd_e), .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
        .md_start_e(md_start_e), .mem_wait(mem_wait),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle's inputs right after a rising edge, then waits for the falling edge.
    task automatic applyStimulus(input logic mr, input logic [4:0] rd,
                                 input logic [4:0] r1, input logic r1u,
                                 input logic [4:0] r2, input logic r2u,
                                 input logic br, input logic md, input logic mw);
        mem_read_e     = mr;
        rd_e           = rd;
        rs1_d          = r1;
        rs1_used       = r1u;
        rs2_d          = r2;
        rs2_used       = r2u;
        branch_taken_e = br;
        md_start_e     = md;
        mem_wait       = mw;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
        checkOutput({tag, "_flush_cnt"}, flush_cnt, 32'(exp_flush));
    endtask

    initial begin
        rst = 1'b0;
        mem_read_e = 0; rd_e = 0; rs1_d = 0; rs1_used = 0; rs2_d = 0; rs2_used = 0;
        branch_taken_e = 0; md_start_e = 0; mem_wait = 0;
        #2;
        checkOutput("reset_ctrl", 32'(ctrl), 32'(C_ZERO));
        checkOutput("reset_busy", 32'(md_busy), 32'd0);
        checkCounters("reset");
        tick();
        rst = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        checkCounters("idle");

        // Load x5 in EX, add x6,x5,x1 in ID: one bubble
        applyStimulus(1, 5, 5, 1, 1, 1, 0, 0, 0);
        checkOutput("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
        tick(); exp_stall++;
        checkCounters("lu_rs1");
        applyStimulus(0, 0, 5, 1, 1, 1, 0, 0, 0);
        checkOutput("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        checkCounters("lu_after");

        applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0);
        checkOutput("lu_x0_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        applyStimulus(1, 7, 3, 1, 7, 0, 0, 0, 0);
        checkOutput("lu_rs2_unused_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        applyStimulus(1, 7, 3, 1, 7, 1, 0, 0, 0);
        checkOutput("lu_rs2_ctrl", 32'(ctrl), 32'(C_LU));
        tick(); exp_stall++;
        checkCounters("lu_rs2");

        // Branch wins over a simultaneous load-use
        applyStimulus(1, 5, 5, 1, 0, 0, 1, 0, 0);
        checkOutput("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
        tick(); exp_flush++;
        checkCounters("br_lu");

        // Mul/div, MD_LAT=4: three stall cycles then advance
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
            if (c < 4) begin
                checkOutput($sformatf("md_c%0d_ctrl", c), 32'(ctrl_md), 32'(C_MD));
                exp_stall++;
            end else begin
                checkOutput("md_c4_ctrl", 32'(ctrl), 32'(C_RUN));
            end
            checkOutput($sformatf("md_c%0d_busy", c), 32'(md_busy), (c > 1) ? 32'd1 : 32'd0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("md_done_ctrl", 32'(ctrl), 32'(C_RUN));
        checkOutput("md_done_busy", 32'(md_busy), 32'd0);
        tick();
        checkCounters("md");

        // Mul/div frozen by mem_wait while md_cnt==1
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, (c == 3 || c == 4));
            if (c == 3 || c == 4) begin
                checkOutput($sformatf("mdw_c%0d_ctrl", c), 32'(ctrl), 32'(C_ZERO));
                checkOutput($sformatf("mdw_c%0d_cnt", c), 32'(dut.md_cnt_q), 32'd1);
                exp_stall++;
            end else if (c < 6) begin
                checkOutput($sformatf("mdw_c%0d_ctrl", c), 32'(ctrl_md), 32'(C_MD));
                exp_stall++;
            end else begin
                checkOutput("mdw_c6_ctrl", 32'(ctrl), 32'(C_RUN));
            end
            tick();
        end
        checkCounters("mdw");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mdw_idle_busy", 32'(md_busy), 32'd0);
        tick();

        // Branch held across a 3-cycle mem_wait is applied exactly once
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
            checkOutput($sformatf("brw_c%0d_ctrl", c), 32'(ctrl), 32'(C_ZERO));
            tick(); exp_stall++;
        end
        checkCounters("brw_hold");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("brw_release_ctrl", 32'(ctrl), 32'(C_BR));
        tick(); exp_flush++;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("brw_after_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        checkCounters("brw");

        // Asynchronous reset in the middle of BUSY
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        checkOutput("arst_pre_busy", 32'(md_busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("arst_ctrl", 32'(ctrl), 32'(C_ZERO));
        checkOutput("arst_busy", 32'(md_busy), 32'd0);
        exp_stall = 0; exp_flush = 0;
        checkCounters("arst");
        #1 rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("arst_rel_ctrl", 32'(ctrl), 32'(C_RUN));
        checkOutput("arst_rel_busy", 32'(md_busy), 32'd0);
        tick();
        checkCounters("arst_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
